pipelined_logic_unit: RTL and testbench

- Parametrised successor to the single-bit pipelined NAND: WIDTH-bit bitwise logic unit with selectable operation and DEPTH register stages.
- Uses a valid/ready handshake with per-stage bubble collapsing, so the pipeline can absorb backpressure without losing or duplicating data.
- Sits between a producer and a consumer stream in Cava monad example designs; serves as the reference pipelined datapath for handshake testbenches.

---
 rtl/pipelined_logic_unit.sv | 95 +++++++++
 tb/tb_pipelined_logic_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_logic_unit.sv
// WIDTH-bit bitwise logic unit (NAND/AND/OR/XOR) with DEPTH valid/ready register stages and bubble collapsing.
// Optional output-transfer counter enabled by defining PIPELINED_LOGIC_UNIT_COUNT_EN.
module pipelined_logic_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
  output logic [15:0]      out_count,
`endif
  output logic [WIDTH-1:0] c
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'd0:    r = ~(x & y);
      2'd1:    r = x & y;
      2'd2:    r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] op_res;

  assign op_res = logic_op(a, b, op);

  // A stage can advance unless it and every stage after it are full while the consumer stalls;
  // written in closed form so the chain has no combinational self-reference.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&v_q[DEPTH-1:k]);
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign c         = d_q[DEPTH-1];

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      d_d[0] = op_res;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Stage registers: reset discards everything in flight, data included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed bench for pipelined_logic_unit: 1-bit/1-stage NAND instance and 8-bit/2-stage instance.
module tb_pipelined_logic_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv1 = 0, ir1, ov1, or1 = 0;
  logic [0:0] a1 = '0, b1 = '0, c1;
  logic [1:0] op1 = '0;

  logic       iv8 = 0, ir8, ov8, or8 = 0;
  logic [7:0] a8 = '0, b8 = '0, c8;
  logic [1:0] op8 = '0;

`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_logic_unit #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(or1),
`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
    .out_count(cnt1),
`endif
    .c(c1));

  pipelined_logic_unit #(.WIDTH(8), .DEPTH(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(or8),
`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
    .out_count(cnt8),
`endif
    .c(c8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] nand_a [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
  logic [1:0] nand_b [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic [1:0] nand_c [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
  logic [7:0] ops_c  [4] = '{8'h3F, 8'hC0, 8'hFC, 8'h3C};

  initial begin
    // Reset state
    #12;
    chk("rst_ov8", 32'(ov8), 32'd0);
    chk("rst_c8", 32'(c8), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("post_rst_ir8", 32'(ir8), 32'd1);
    chk("post_rst_ir1", 32'(ir1), 32'd1);

    // 1-bit NAND truth table, one-cycle latency
    or1 = 1'b1;
    op1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1;
      a1  = nand_a[i][0:0];
      b1  = nand_b[i][0:0];
      tick();
      chk($sformatf("nand_ov%0d", i), 32'(ov1), 32'd1);
      chk($sformatf("nand_c%0d", i), 32'(c1), 32'(nand_c[i]));
    end
    iv1 = 1'b0;
    tick();
    chk("nand_drain_ov", 32'(ov1), 32'd0);

    // All four ops back-to-back, two-edge latency
    or8 = 1'b1;
    a8  = 8'hF0;
    b8  = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      iv8 = 1'b1;
      op8 = 2'(i);
      tick();
      if (i == 0) chk("ops_lat_ov", 32'(ov8), 32'd0);
      else begin
        chk($sformatf("ops_ov%0d", i - 1), 32'(ov8), 32'd1);
        chk($sformatf("ops_c%0d", i - 1), 32'(c8), 32'(ops_c[i-1]));
      end
    end
    iv8 = 1'b0;
    tick();
    chk("ops_ov3", 32'(ov8), 32'd1);
    chk("ops_c3", 32'(c8), 32'(ops_c[3]));
    tick();
    chk("ops_drain_ov", 32'(ov8), 32'd0);

    // Backpressure fill: pass-through via AND with all-ones
    op8 = 2'd1;
    b8  = 8'hFF;
    or8 = 1'b0;
    iv8 = 1'b1;
    a8  = 8'h11;
    #1 chk("bp_ir_0", 32'(ir8), 32'd1);
    tick();
    a8 = 8'h22;
    #1 chk("bp_ir_1", 32'(ir8), 32'd1);
    tick();
    a8 = 8'h33;
    chk("bp_full_ov", 32'(ov8), 32'd1);
    chk("bp_full_c", 32'(c8), 32'h11);
    #1 chk("bp_ir_full", 32'(ir8), 32'd0);
    tick();
    chk("bp_stable_c1", 32'(c8), 32'h11);
    chk("bp_ir_hold", 32'(ir8), 32'd0);
    tick();
    chk("bp_stable_c2", 32'(c8), 32'h11);

    // Full pipeline with out_ready=1: simultaneous in/out transfer
    or8 = 1'b1;
    #1 chk("full_rdy_ir", 32'(ir8), 32'd1);
    tick();
    chk("bp_out_c22", 32'(c8), 32'h22);
    or8 = 1'b0;
    #1 chk("occupancy_full", 32'(ir8), 32'd0);
    or8 = 1'b1;
    a8  = 8'h44;
    tick();
    chk("bp_out_c33", 32'(c8), 32'h33);
    iv8 = 1'b0;
    tick();
    chk("bp_out_ov44", 32'(ov8), 32'd1);
    chk("bp_out_c44", 32'(c8), 32'h44);
    tick();
    chk("bp_drain_ov", 32'(ov8), 32'd0);

    // Reset between edges with a full pipeline
    or8 = 1'b0;
    iv8 = 1'b1;
    a8  = 8'h55;
    tick();
    a8 = 8'h66;
    tick();
    iv8 = 1'b0;
    chk("mid_full_ir", 32'(ir8), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(ov8), 32'd0);
    chk("mid_rst_c", 32'(c8), 32'd0);
    #2 rst = 1'b0;
    or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("no_stale%0d", i), 32'(ov8), 32'd0);
    end
    iv8 = 1'b1;
    a8  = 8'h77;
    tick();
    iv8 = 1'b0;
    tick();
    chk("post_mid_ov", 32'(ov8), 32'd1);
    chk("post_mid_c", 32'(c8), 32'h77);
    tick();
    chk("post_mid_drain", 32'(ov8), 32'd0);

`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
    // One transfer (0x77) since reset; four more make five
    iv8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'(i + 1);
      tick();
    end
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    chk("count5", 32'(cnt8), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
